// File: rtl/packer_cfg_sequencer.sv
// Shadow table of per-chain {cond, fw} bytes plus an apply sequencer that drops tracing, drains, streams block images and restores tracing.
// Define PACKER_CFG_READBACK_EN to add the registered rd_block/rd_chain -> rd_data readback port.
module packer_cfg_sequencer #(
  parameter int         MAX_CHAINS     = 4,
  parameter int         NUM_BLOCKS     = 8,
  parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF,
  parameter int         DRAIN_CYCLES   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing_req,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_BLOCKS)-1:0] wr_block,
  input  logic [$clog2(MAX_CHAINS)-1:0] wr_chain,
  input  logic [7:0]                    wr_cond,
  input  logic [7:0]                    wr_fw,
  input  logic                          apply_valid,
  output logic                          apply_ready,
  input  logic [NUM_BLOCKS-1:0]         apply_mask,
  output logic                          tracing,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData,
  output logic                          busy,
  output logic                          done
`ifdef PACKER_CFG_READBACK_EN
  ,
  input  logic [$clog2(NUM_BLOCKS)-1:0] rd_block,
  input  logic [$clog2(MAX_CHAINS)-1:0] rd_chain,
  output logic [15:0]                   rd_data
`endif
);

  localparam int BLK_W = $clog2(NUM_BLOCKS);
  localparam int CH_W  = $clog2(MAX_CHAINS);
  localparam int IDX_W = $clog2(2 * MAX_CHAINS);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2 * MAX_CHAINS - 1);
  localparam logic [IDX_W-1:0] FW_BASE    = IDX_W'(MAX_CHAINS);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_STREAM, S_GAP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_BLOCKS-1:0] pend_q, pend_d;
  logic [BLK_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [7:0] cond_q [NUM_BLOCKS][MAX_CHAINS];
  logic [7:0] cond_d [NUM_BLOCKS][MAX_CHAINS];
  logic [7:0] fw_q   [NUM_BLOCKS][MAX_CHAINS];
  logic [7:0] fw_d   [NUM_BLOCKS][MAX_CHAINS];

  logic       tracing_q, tracing_d;
  logic [7:0] config_id_q, config_id_d;
  logic [7:0] config_data_q, config_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [7:0] stream_byte;
  logic       wr_en, apply_en;

  // Handshakes: a request is taken at the rising edge where valid and the
  // registered ready are both 1; ready is 1 exactly while the sequencer is idle.
  assign wr_en    = wr_valid && ready_q;
  assign apply_en = apply_valid && ready_q;

  function automatic logic [BLK_W-1:0] lowest_bit(input logic [NUM_BLOCKS-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = BLK_W'(i);
    end
  endfunction

  always_comb begin
    cond_d = cond_q;
    fw_d   = fw_q;
    if (wr_en) begin
      cond_d[wr_block][wr_chain] = wr_cond;
      fw_d[wr_block][wr_chain]   = wr_fw;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (apply_en) begin
          pend_d  = apply_mask;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          if (pend_q != '0) begin
            cur_d   = lowest_bit(pend_q);
            idx_d   = '0;
            state_d = S_STREAM;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          pend_d[cur_q] = 1'b0;
          state_d       = S_GAP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_GAP: begin
        if (pend_q != '0) begin
          cur_d   = lowest_bit(pend_q);
          idx_d   = '0;
          state_d = S_STREAM;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they land in flops aligned with it.
  always_comb begin
    stream_byte = 8'h00;
    if (idx_d < FW_BASE) stream_byte = cond_q[cur_d][CH_W'(idx_d)];
    else                 stream_byte = fw_q[cur_d][CH_W'(idx_d - FW_BASE)];
  end

  always_comb begin
    busy_d        = (state_d != S_IDLE);
    ready_d       = (state_d == S_IDLE);
    done_d        = (state_d == S_DONE);
    tracing_d     = (state_d == S_IDLE) ? tracing_req : 1'b0;
    config_id_d   = IDLE_CONFIG_ID;
    config_data_d = 8'h00;
    if (state_d == S_STREAM) begin
      config_id_d   = 8'(cur_d);
      config_data_d = stream_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      cur_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      tracing_q     <= 1'b0;
      config_id_q   <= IDLE_CONFIG_ID;
      config_data_q <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        for (int c = 0; c < MAX_CHAINS; c++) begin
          cond_q[b][c] <= 8'h00;
          fw_q[b][c]   <= 8'h00;
        end
      end
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      cur_q         <= cur_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tracing_q     <= tracing_d;
      config_id_q   <= config_id_d;
      config_data_q <= config_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
      cond_q        <= cond_d;
      fw_q          <= fw_d;
    end
  end

  assign wr_ready    = ready_q;
  assign apply_ready = ready_q;
  assign tracing     = tracing_q;
  assign configId    = config_id_q;
  assign configData  = config_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef PACKER_CFG_READBACK_EN
  logic [15:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = {cond_q[rd_block][rd_chain], fw_q[rd_block][rd_chain]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= 16'h0000;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: doc/packer_cfg_sequencer.md
# packer_cfg_sequencer

Configuration sequencer for the data-packer instrumentation blocks. It holds a shadow table of per-chain condition and firmware bytes for up to NUM_BLOCKS config targets. On an apply request it drops `tracing`, waits for the pipeline to drain, then streams each selected block's full byte image over the shared `configId`/`configData` bus. When streaming finishes it restores `tracing`. It sits between the host control interface and every block that consumes `configId`/`configData`.

## Interface
- `MAX_CHAINS`, 4: chains per block; each block image is 2*MAX_CHAINS bytes.
- `NUM_BLOCKS`, 8: addressable config targets; block b is addressed as configId b.
- `IDLE_CONFIG_ID`, 8'hFF: configId driven when no block is addressed; must be ≥ NUM_BLOCKS.
- `DRAIN_CYCLES`, 4: cycles `tracing` stays low before the first byte is driven; must be ≥1.
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `tracing_req` in 1: host's requested tracing state.
- `wr_valid` in 1: shadow write request.
- `wr_ready` out 1: shadow write accepted; equals !busy.
- `wr_block` in $clog2(NUM_BLOCKS): block index for the write.
- `wr_chain` in $clog2(MAX_CHAINS): chain index for the write.
- `wr_cond` in 8: condition byte to store.
- `wr_fw` in 8: firmware byte to store.
- `apply_valid` in 1: apply request.
- `apply_ready` out 1: apply accepted; equals !busy.
- `apply_mask` in NUM_BLOCKS: blocks to reprogram.
- `tracing` out 1: tracing enable driven to all blocks.
- `configId` out 8: config target id.
- `configData` out 8: config byte.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at the end of a sequence.

## Operation
- Shadow table: NUM_BLOCKS×MAX_CHAINS entries of {cond, fw}. Reset sets every entry to 0 (cond = none, fw = full-N).
- Write: on `wr_valid && wr_ready`, entry [wr_block][wr_chain] is updated at the clock edge. While busy, writes are not accepted and the table is unchanged.
- FSM states: IDLE, DRAIN, STREAM, GAP, DONE.
- IDLE
  - `tracing` <= `tracing_req`; `configId` = IDLE_CONFIG_ID; `configData` = 0.
  - On `apply_valid && apply_ready`: latch `apply_mask` into `pend`, go to DRAIN.
- DRAIN
  - `tracing` = 0; `configId` = IDLE_CONFIG_ID.
  - Counts DRAIN_CYCLES cycles.
  - If `pend` ≠ 0: go to STREAM with `cur` = lowest set bit of `pend` and `idx` = 0. Otherwise go to DONE.
- STREAM
  - `configId` = `cur`.
  - `configData` = cond[cur][idx] when idx < MAX_CHAINS, else fw[cur][idx−MAX_CHAINS].
  - `idx` increments each cycle. After idx = 2*MAX_CHAINS−1, clear bit `cur` in `pend` and go to GAP.
- GAP
  - One cycle with `configId` = IDLE_CONFIG_ID. This resets the target's byte counter.
  - If `pend` ≠ 0, go to STREAM with the next lowest set bit; otherwise go to DONE.
- DONE
  - `done` = 1 for one cycle; `tracing` stays 0.
  - Next cycle returns to IDLE, and `tracing` follows `tracing_req`.
- `busy` = 1 in every state except IDLE.
- Reset mid-sequence: returns to IDLE and clears `pend`. The shadow table is reinitialised to 0. The target blocks may hold partial images; the host re-applies.
- `apply_mask` bits ≥ NUM_BLOCKS do not exist. Blocks are always sent in ascending index order.

## Timing
- All outputs are registered.
- Reset values: `tracing`=0, `configId`=IDLE_CONFIG_ID, `configData`=0, `busy`=0, `done`=0, `wr_ready`=1, `apply_ready`=1.
- Apply accepted at edge T:
  - `tracing`=0 and `busy`=1 from T+1.
  - First STREAM byte at T+1+DRAIN_CYCLES.
- Total sequence length, from T+1 through the DONE cycle inclusive: DRAIN_CYCLES + k*(2*MAX_CHAINS+1) + 1, where k = popcount(mask).
- `tracing_req` to `tracing` latency in IDLE: 1 cycle.
- A write and an apply in the same cycle are both accepted; the write is committed before the first STREAM read.

## Configuration
- `PACKER_CFG_READBACK_EN` defined: adds a readback port.
  - Inputs: `rd_block`, `rd_chain`.
  - Output: 16-bit `rd_data` = {cond, fw}, registered with 1-cycle latency, valid in any state.
- Undefined: the readback port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then hold `tracing_req`=1 → `tracing`=1 from the second cycle; `configId`=8'hFF; shadow table reads 0.
- Write block 2, chain 1 with cond=8'h01, fw=8'h02; apply mask 8'b0000_0100 → after 4 drain cycles, configId=2 for 8 cycles with data 00,01,00,00,00,02,00,00; one 8'hFF gap; `done` pulse; `tracing`=1 again.
- Apply mask 8'b1000_0001 → blocks 0 then 7, separated by exactly one 8'hFF cycle; sequence length 4+2*9+1 = 23 cycles.
- Apply mask 0 → 4 drain cycles then `done`; no configId other than 8'hFF appears.
- Assert `wr_valid` while busy → `wr_ready`=0 and readback shows the entry unchanged; a second `apply_valid` during busy is not accepted.
- Assert reset in the STREAM state at idx=3 → next cycle all outputs are at reset values; `pend` is cleared and no `done` pulse occurs.
